// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral and its prescaler.
// Counter width, full-duty code, output count, default prescale.
package pwm_pkg;

    localparam int          PWM_CNT_W            = 8;
    localparam logic [7:0]  DUTY_FULL            = 8'hFF;
    localparam int          NUM_OUTPUTS          = 16;
    localparam int          DEFAULT_PRESCALE_DIV = 3000;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: emits a one-clk tick every PRESCALE_DIV clocks.
// Ports: clk, rst_n (async active-low), tick (combinational from count).
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV,
    parameter int PRESCALE_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LP_LAST =
        PRESCALE_W'(PRESCALE_DIV - 1);

    logic [PRESCALE_W-1:0] r_pre_cnt;

    // With PRESCALE_DIV = 1 the count stays at 0 and tick is constant.
    assign tick = (r_pre_cnt == LP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral: shared 8-bit PWM counter, double-buffered duty,
// per-output off/static-high/PWM select, registered 16-bit outputs.
// Ports: clk, rst_n, en_reg_out_*, en_reg_pwm_*, pwm_duty_cycle,
// out[15:0], period_start (one-clk pulse at counter wrap).
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV,
    parameter int PRESCALE_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             en_reg_out_7_0,
    input  logic [7:0]             en_reg_out_15_8,
    input  logic [7:0]             en_reg_pwm_7_0,
    input  logic [7:0]             en_reg_pwm_15_8,
    input  logic [7:0]             pwm_duty_cycle,
    output logic [NUM_OUTPUTS-1:0] out,
    output logic                   period_start
);

    logic                   w_tick;
    logic                   w_wrap;
    logic                   w_pwm;
    logic [NUM_OUTPUTS-1:0] w_en_out;
    logic [NUM_OUTPUTS-1:0] w_en_pwm;
    logic [NUM_OUTPUTS-1:0] w_next_out;

    logic [PWM_CNT_W-1:0]   r_cnt;
    logic [PWM_CNT_W-1:0]   r_duty_q;
    logic [NUM_OUTPUTS-1:0] r_out;
    logic                   r_period_start;

    pwm_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV),
        .PRESCALE_W   (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_wrap = w_tick && (r_cnt == '1);

    // Full duty is special-cased so the cnt == 255 tick stays high.
    assign w_pwm = (r_duty_q == DUTY_FULL) || (r_cnt < r_duty_q);

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Disabled outputs are low regardless of PWM mode.
    assign w_next_out = w_en_out & (~w_en_pwm | {NUM_OUTPUTS{w_pwm}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_duty_q       <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_next_out;
            r_period_start <= w_wrap;
            if (w_tick) begin
                r_cnt <= r_cnt + PWM_CNT_W'(1);
            end
            // New duty only takes effect at the period boundary.
            if (w_wrap) begin
                r_duty_q <= pwm_duty_cycle;
            end
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration bytes written over SPI (output enables, PWM-mode enables, duty cycle) and drives the 16 user outputs.
- Each output is forced low, driven static high, or driven with one shared PWM waveform.
- Sits directly downstream of the SPI register file; its inputs are stable, clk-domain register values.
- One shared prescaled 8-bit counter generates the waveform. Duty updates are double-buffered so they take effect only at period boundaries.

Parameters:
- PRESCALE_DIV, 3000: clk cycles per PWM counter tick; legal range 1..65535 (10 MHz / 3000 / 256 ≈ 13 Hz period).
- PRESCALE_W, 16: prescaler counter width; must satisfy 2^PRESCALE_W >= PRESCALE_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, outputs 7..0
- en_reg_out_15_8  input  8  output enable, outputs 15..8
- en_reg_pwm_7_0  input  8  PWM-mode enable, outputs 7..0
- en_reg_pwm_15_8  input  8  PWM-mode enable, outputs 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  registered user outputs
- period_start  output  1  one-clk pulse, registered, asserted on the clk the counter wraps to 0

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n). All state is reset asynchronously and released synchronously to clk.
- Reset values:
  - out = 16'h0000, period_start = 0.
  - Prescaler count = 0, PWM count = 0.
  - Duty shadow = 8'h00.
- Prescaler:
  - pre_cnt counts 0..PRESCALE_DIV-1 and wraps.
  - tick = 1 on the clk where pre_cnt == PRESCALE_DIV-1.
  - PRESCALE_DIV = 1 gives tick every clk.
- PWM counter:
  - cnt (8 bit) increments by 1 on each tick and wraps 255 -> 0.
  - On a tick with cnt == 255: cnt <= 0, duty_q <= pwm_duty_cycle, period_start <= 1.
  - period_start is 0 on every other clk.
- Duty changes mid-period are ignored until the next wrap. The first period after reset therefore uses duty 0.
- PWM signal (combinational from registered state): pwm = (duty_q == 8'hFF) | (cnt < duty_q).
  - Duty 0x00: always low.
  - Duty 0xFF: always high, no 1-tick glitch.
  - Otherwise: high for duty_q ticks of each 256-tick period.
- Per output i (en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm likewise):
  - next_out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
  - en_out = 0 overrides en_pwm.
- Latency:
  - out is registered: out <= next_out every clk.
  - Enable changes appear on out 1 clk later.
  - pwm edges appear 1 clk after the cnt update that causes them.
- Phase: all PWM outputs share one counter and are phase-aligned, with rising edges at cnt == 0.
- Simultaneous events:
  - A duty change on the same clk as the wrap is captured; duty_q takes the new value.
  - Enable changes on any clk are independent of the period.
- Reset mid-period: all state clears immediately (async). After release, counting restarts from pre_cnt = 0, cnt = 0, duty_q = 0.
- No combinational path from inputs to out.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W = 8.
  - DUTY_FULL = 8'hFF.
  - NUM_OUTPUTS = 16.
  - Default PRESCALE_DIV value.
- Sub-module pwm_prescaler:
  - Parameters PRESCALE_DIV, PRESCALE_W.
  - Ports clk, rst_n, tick.
  - Reused by future timer blocks.
- Top level holds the PWM counter, duty shadow, output mux and output registers.

Test Plan:
- Reset, PRESCALE_DIV=4, all enables 0, duty 0x80, run 3000 clk -> out stays 16'h0000; period_start pulses every 1024 clk.
- en_reg_out_7_0=0xFF, en_reg_pwm=0 -> out[7:0]=0xFF exactly 1 clk after the write; out[15:8]=0x00.
- PRESCALE_DIV=1, en_out=en_pwm=0xFFFF, duty=0x40 applied before a wrap -> in the following period, out=0xFFFF for exactly 64 clk and 0x0000 for 192 clk.
- Duty 0x00 -> out constant 0. Duty 0xFF -> out constant 0xFFFF across 3 full periods, with no low cycle at the wrap.
- Change duty 0x40 -> 0xC0 mid-period -> current period keeps 64-tick high time; next period has 192-tick high time, starting at the period_start clk.
- Assert rst_n low mid-period with out high -> out=0 immediately, without waiting for clk. After release, first period_start occurs 256*PRESCALE_DIV clk later and duty_q=0 until then.
